// File: rtl/apu_mixer.sv
`default_nettype none
// ============================================================================
// Module   : apu_mixer
// Purpose  : Stereo mixer. Sums four channel codes plus VIN per side over four
//            APU clocks and scales each sum by its master volume.
// Revision : 1.0 - initial release
// ============================================================================
module apu_mixer (
  input  logic       apuv_4mhz,
  input  logic       napu_reset,
  input  logic       dyfa_1mhz,
  input  logic [3:0] ch1_amp,
  input  logic [3:0] ch2_amp,
  input  logic [3:0] ch3_amp,
  input  logic [3:0] ch4_amp,
  input  logic       nch1_active,
  input  logic       nch2_active,
  input  logic       nch3_active,
  input  logic       nch4_active,
  input  logic [3:0] rmixer,
  input  logic [3:0] lmixer,
  input  logic [2:0] nrvolume,
  input  logic [2:0] nlvolume,
  input  logic       vin_r_ena,
  input  logic       vin_l_ena,
  input  logic [3:0] vin_amp,
  output logic [9:0] rout,
  output logic [9:0] lout,
  output logic       sample_valid,
  output logic       overrun
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  localparam logic [1:0] c_last_step = 2'd3;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_step;
  logic [1:0] w_step_nxt;
  logic       r_dyfa_q;

  logic       w_req;
  logic       w_last;
  logic       w_accept;
  logic       w_drop;

  // Frame snapshot; volumes are stored already de-inverted, actives active-high.
  logic [15:0] r_amp;
  logic [3:0]  r_active;
  logic [3:0]  r_lmix;
  logic [3:0]  r_rmix;
  logic [2:0]  r_lvol;
  logic [2:0]  r_rvol;
  logic        r_vin_l;
  logic        r_vin_r;
  logic [3:0]  r_vin_amp;

  logic [6:0]  r_acc_l;
  logic [6:0]  r_acc_r;

  logic [3:0]  w_amp_sel;
  logic        w_ch_on;
  logic [3:0]  w_term_l;
  logic [3:0]  w_term_r;
  logic [3:0]  w_vterm_l;
  logic [3:0]  w_vterm_r;
  logic [6:0]  w_sum_l;
  logic [6:0]  w_sum_r;
  logic [3:0]  w_gain_l;
  logic [3:0]  w_gain_r;
  logic [9:0]  w_mix_l;
  logic [9:0]  w_mix_r;

  assign w_req    = dyfa_1mhz & ~r_dyfa_q;
  assign w_last   = (r_state == ST_ACC) && (r_step == c_last_step);
  assign w_accept = w_req && ((r_state == ST_IDLE) || w_last);
  assign w_drop   = w_req && (r_state == ST_ACC) && !w_last;

  assign w_amp_sel = r_amp[{r_step, 2'b00} +: 4];
  assign w_ch_on   = r_active[r_step];
  assign w_term_l  = (r_lmix[r_step] && w_ch_on) ? w_amp_sel : 4'd0;
  assign w_term_r  = (r_rmix[r_step] && w_ch_on) ? w_amp_sel : 4'd0;
  assign w_vterm_l = r_vin_l ? r_vin_amp : 4'd0;
  assign w_vterm_r = r_vin_r ? r_vin_amp : 4'd0;

  // Peak sum is 75 and peak product 600, so neither needs saturation.
  assign w_sum_l  = r_acc_l + {3'd0, w_term_l} + {3'd0, w_vterm_l};
  assign w_sum_r  = r_acc_r + {3'd0, w_term_r} + {3'd0, w_vterm_r};
  assign w_gain_l = {1'b0, r_lvol} + 4'd1;
  assign w_gain_r = {1'b0, r_rvol} + 4'd1;
  assign w_mix_l  = {3'd0, w_sum_l} * {6'd0, w_gain_l};
  assign w_mix_r  = {3'd0, w_sum_r} * {6'd0, w_gain_r};

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (w_accept) begin
      w_state_nxt = ST_ACC;
      w_step_nxt  = 2'd0;
    end else if (r_state == ST_ACC) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_step_nxt  = 2'd0;
      end else begin
        w_step_nxt = r_step + 2'd1;
      end
    end
  end

  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      r_state  <= ST_IDLE;
      r_step   <= 2'd0;
      r_dyfa_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_dyfa_q <= dyfa_1mhz;
    end
  end

  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      r_amp     <= 16'd0;
      r_active  <= 4'd0;
      r_lmix    <= 4'd0;
      r_rmix    <= 4'd0;
      r_lvol    <= 3'd0;
      r_rvol    <= 3'd0;
      r_vin_l   <= 1'b0;
      r_vin_r   <= 1'b0;
      r_vin_amp <= 4'd0;
      r_acc_l   <= 7'd0;
      r_acc_r   <= 7'd0;
    end else if (w_accept) begin
      r_amp     <= {ch4_amp, ch3_amp, ch2_amp, ch1_amp};
      r_active  <= ~{nch4_active, nch3_active, nch2_active, nch1_active};
      r_lmix    <= lmixer;
      r_rmix    <= rmixer;
      r_lvol    <= ~nlvolume;
      r_rvol    <= ~nrvolume;
      r_vin_l   <= vin_l_ena;
      r_vin_r   <= vin_r_ena;
      r_vin_amp <= vin_amp;
      r_acc_l   <= 7'd0;
      r_acc_r   <= 7'd0;
    end else if ((r_state == ST_ACC) && !w_last) begin
      r_acc_l <= r_acc_l + {3'd0, w_term_l};
      r_acc_r <= r_acc_r + {3'd0, w_term_r};
    end
  end

  // Output stage reads the accumulators before a restarting frame clears them.
  always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      lout         <= 10'd0;
      rout         <= 10'd0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= w_last;
      if (w_last) begin
        lout <= w_mix_l;
        rout <= w_mix_r;
      end
      if (w_drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apu_mixer.sv
`default_nettype none
// Self-checking bench for apu_mixer: directed scenarios plus randomized frames
// compared against an arithmetic model of the mix rules.
module tb_apu_mixer;

  logic       clk = 1'b0;
  logic       napu_reset;
  logic       dyfa;
  logic [3:0] amp [4];
  logic       nact [4];
  logic [3:0] rmixer, lmixer;
  logic [2:0] nrvolume, nlvolume;
  logic       vin_r_ena, vin_l_ena;
  logic [3:0] vin_amp;
  logic [9:0] rout, lout;
  logic       sample_valid, overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apu_mixer dut (
    .apuv_4mhz   (clk),
    .napu_reset  (napu_reset),
    .dyfa_1mhz   (dyfa),
    .ch1_amp     (amp[0]),
    .ch2_amp     (amp[1]),
    .ch3_amp     (amp[2]),
    .ch4_amp     (amp[3]),
    .nch1_active (nact[0]),
    .nch2_active (nact[1]),
    .nch3_active (nact[2]),
    .nch4_active (nact[3]),
    .rmixer      (rmixer),
    .lmixer      (lmixer),
    .nrvolume    (nrvolume),
    .nlvolume    (nlvolume),
    .vin_r_ena   (vin_r_ena),
    .vin_l_ena   (vin_l_ena),
    .vin_amp     (vin_amp),
    .rout        (rout),
    .lout        (lout),
    .sample_valid(sample_valid),
    .overrun     (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected sample for one side from the live inputs.
  function automatic int model(input bit left);
    int sum = 0;
    int vol;
    for (int c = 0; c < 4; c++)
      if ((left ? lmixer[c] : rmixer[c]) && !nact[c]) sum += int'(amp[c]);
    if (left ? vin_l_ena : vin_r_ena) sum += int'(vin_amp);
    vol = 7 - int'(left ? nlvolume : nrvolume);
    return sum * (vol + 1);
  endfunction

  task automatic clear_inputs();
    for (int c = 0; c < 4; c++) begin
      amp[c]  = 4'd0;
      nact[c] = 1'b1;
    end
    rmixer = 4'd0; lmixer = 4'd0;
    nrvolume = 3'd0; nlvolume = 3'd0;
    vin_r_ena = 1'b0; vin_l_ena = 1'b0; vin_amp = 4'd0;
  endtask

  task automatic set_single();
    clear_inputs();
    amp[0] = 4'd15; nact[0] = 1'b0; lmixer = 4'b0001;
  endtask

  // One isolated frame: rising edge accepted on the first tick, result 4 ticks later.
  task automatic run_frame(input string tag, input int exp_l, input int exp_r);
    dyfa = 1'b1;
    tick();
    dyfa = 1'b0;
    repeat (3) tick();
    check({tag, "_early_valid"}, 32'(sample_valid), 0);
    tick();
    check({tag, "_valid"}, 32'(sample_valid), 1);
    check({tag, "_lout"}, 32'(lout), exp_l);
    check({tag, "_rout"}, 32'(rout), exp_r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int el, er;
    napu_reset = 1'b0;
    dyfa = 1'b0;
    clear_inputs();

    // Reset held: toggling inputs must not move any output.
    for (int i = 0; i < 6; i++) begin
      dyfa = i[0];
      for (int c = 0; c < 4; c++) begin
        amp[c] = 4'($urandom);
        nact[c] = 1'($urandom);
      end
      lmixer = 4'($urandom); rmixer = 4'($urandom);
      vin_amp = 4'($urandom); vin_l_ena = 1'b1; vin_r_ena = 1'b1;
      tick();
      check("rst_lout", 32'(lout), 0);
      check("rst_rout", 32'(rout), 0);
      check("rst_valid", 32'(sample_valid), 0);
      check("rst_overrun", 32'(overrun), 0);
    end

    // Release with dyfa already high: sample_valid exactly five clocks later.
    clear_inputs();
    dyfa = 1'b1;
    napu_reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("rel_valid_wait", 32'(sample_valid), 0);
    end
    tick();
    check("rel_valid", 32'(sample_valid), 1);
    dyfa = 1'b0;
    tick();
    check("rel_valid_drop", 32'(sample_valid), 0);
    tick();

    set_single();
    run_frame("single", 120, 0);
    tick();
    check("single_valid_drop", 32'(sample_valid), 0);
    check("single_hold", 32'(lout), 120);

    // Full scale, then right volume 0, then channel 3 off.
    for (int c = 0; c < 4; c++) begin
      amp[c] = 4'd15; nact[c] = 1'b0;
    end
    lmixer = 4'hF; rmixer = 4'hF;
    vin_l_ena = 1'b1; vin_r_ena = 1'b1; vin_amp = 4'd15;
    nlvolume = 3'd0; nrvolume = 3'd0;
    run_frame("full", 600, 600);
    nrvolume = 3'b111;
    run_frame("full_rvol0", 600, 75);
    nact[2] = 1'b1;
    run_frame("full_ch3off", 480, 60);

    // Snapshot isolation on ch2.
    clear_inputs();
    amp[1] = 4'd4; nact[1] = 1'b0; lmixer = 4'b0010; rmixer = 4'b0010;
    dyfa = 1'b1;
    tick();
    dyfa = 1'b0;
    amp[1] = 4'd9;
    repeat (4) tick();
    check("snap_valid", 32'(sample_valid), 1);
    check("snap_lout", 32'(lout), 32);
    check("snap_rout", 32'(rout), 32);
    run_frame("snap_next", 72, 72);

    // Clean 1 MHz stream: one valid every 4th clock, no overrun.
    set_single();
    for (int i = 0; i < 24; i++) begin
      dyfa = ((i % 4) < 2);
      tick();
      check("stream_valid", 32'(sample_valid), (i >= 4 && (i % 4) == 0) ? 1 : 0);
      if (i >= 4 && (i % 4) == 0) check("stream_lout", 32'(lout), 120);
    end
    dyfa = 1'b0;
    repeat (4) tick();
    check("stream_overrun", 32'(overrun), 0);

    // Extra edge two clocks into a frame is dropped and flagged.
    clear_inputs();
    amp[3] = 4'd10; nact[3] = 1'b0; rmixer = 4'b1000; nrvolume = 3'd5;
    el = model(1'b1); er = model(1'b0);
    dyfa = 1'b1; tick();
    dyfa = 1'b0; tick();
    dyfa = 1'b1; tick();
    dyfa = 1'b0; tick();
    tick();
    check("drop_valid", 32'(sample_valid), 1);
    check("drop_rout", 32'(rout), er);
    check("drop_lout", 32'(lout), el);
    check("drop_overrun", 32'(overrun), 1);
    tick();
    check("drop_single_pulse", 32'(sample_valid), 0);
    set_single();
    run_frame("after_drop", 120, 0);
    check("overrun_sticky", 32'(overrun), 1);

    // Reset during step 1 aborts the frame.
    clear_inputs();
    amp[0] = 4'd7; nact[0] = 1'b0; rmixer = 4'b0001;
    dyfa = 1'b1; tick();
    dyfa = 1'b0; tick();
    napu_reset = 1'b0;
    #1;
    check("midrst_lout", 32'(lout), 0);
    check("midrst_rout", 32'(rout), 0);
    check("midrst_overrun", 32'(overrun), 0);
    tick();
    napu_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_valid", 32'(sample_valid), 0);
    end
    set_single();
    run_frame("midrst_fresh", 120, 0);

    // Randomized frames against the model.
    for (int n = 0; n < 24; n++) begin
      for (int c = 0; c < 4; c++) begin
        amp[c] = 4'($urandom);
        nact[c] = 1'($urandom);
      end
      lmixer = 4'($urandom); rmixer = 4'($urandom);
      nlvolume = 3'($urandom); nrvolume = 3'($urandom);
      vin_l_ena = 1'($urandom); vin_r_ena = 1'($urandom);
      vin_amp = 4'($urandom);
      run_frame("rand", model(1'b1), model(1'b0));
      tick();
    end
    check("final_overrun", 32'(overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apu_mixer.md
# apu_mixer

Digital stereo mixer stage directly downstream of the APU control block. It consumes that block's NR50/NR51 decode (per-channel left/right enables, inverted 3-bit master volumes, VIN enables) and the 1 MHz APU clock. It time-multiplexes the four channel amplitudes plus VIN into registered 10-bit left/right sample words once per 1 MHz period. The words feed the DAC/output model.

## Interface
- No parameters.
- apuv_4mhz  in  1  APU clock; all state updates on rising edge.
- napu_reset  in  1  asynchronous, active-low reset.
- dyfa_1mhz  in  1  1 MHz square wave; rising edge (sampled in apuv_4mhz domain) requests one mix frame.
- ch1_amp, ch2_amp, ch3_amp, ch4_amp  in  4 each  unsigned channel DAC codes.
- nch1_active, nch2_active, nch3_active, nch4_active  in  1 each  active-low channel-on; an inactive channel contributes 0.
- rmixer, lmixer  in  4  NR51 enables; bit0=ch1 … bit3=ch4.
- nrvolume, nlvolume  in  3  inverted NR50 volumes; effective vol = ~nvolume (0..7).
- vin_r_ena, vin_l_ena  in  1  NR50 VIN routing enables.
- vin_amp  in  4  unsigned cartridge VIN code.
- rout, lout  out  10  mixed samples, (sum) × (vol+1).
- sample_valid  out  1  one-cycle pulse when rout/lout update.
- overrun  out  1  sticky; a frame request was dropped.

## Operation
- Edge detect: register dyfa_q <= dyfa_1mhz; req = dyfa_1mhz & !dyfa_q.
- States:
  - IDLE.
  - ACC with step counter 0..3.
- Request acceptance: a request is accepted in IDLE or in ACC step 3. On acceptance:
  - Snapshot all inputs except dyfa_1mhz into frame registers: amps, active flags, both mixers, both volumes, VIN enables, vin_amp.
  - Clear acc_l and acc_r to 0.
  - Go to ACC step 0.
- Frame math: every ACC step uses snapshot values only. Live input changes mid-frame do not affect the current frame.
- Term definitions, for side s in {l, r} and step n:
  - term_s(n) = ch(n+1)_amp if mixer_s[n] and channel n+1 active, else 0.
  - vterm_s = vin_amp if vin_s_ena, else 0.
- Steps 0..2: acc_s <= acc_s + term_s(n). acc is 7 bits wide.
- Step 3: out_s <= (acc_s + term_s(3) + vterm_s) × (vol_s + 1), and sample_valid <= 1.
  - If no request is accepted, go to IDLE.
  - If a request arrives in the same cycle, it is accepted and the frame restarts at step 0 with no gap.
- Dropped request: a request in ACC steps 0..2 is ignored. The running frame completes unchanged and overrun <= 1.
- Width rules:
  - Max sum = 5 × 15 = 75 (7 bits). Max output = 75 × 8 = 600. Fits 10 bits; no saturation is needed.
  - Multiply is exact, unsigned.
- rout/lout hold their value between frames.

## Timing
- Reset values:
  - rout = lout = 0, sample_valid = 0, overrun = 0.
  - State IDLE, dyfa_q = 0, acc = 0, snapshot = 0.
- Reset asserted mid-frame: immediate abort to reset values; the partial frame is never output.
- After reset release with dyfa_1mhz already high, the first clock sees req = 1 and a frame starts.
- Latency: request sampled at clock k (acceptance). Steps 0..3 execute at clocks k+1..k+4. rout/lout/sample_valid are visible after clock k+4. sample_valid drops after clock k+5 unless step 3 recurs.
- Steady state with a clean 1 MHz input: req every 4 clocks, which always lands on step 3. One sample per 1 MHz period, no overrun.
- overrun clears only on reset.

## Test plan
- Reset state: hold napu_reset low, toggle all inputs -> all outputs stay 0. Release with dyfa_1mhz high -> sample_valid exactly 5 clocks later.
- Single-channel mix:
  - Setup: ch1_amp=15, ch1 active, lmixer=0001, rmixer=0000, nlvolume=000 (vol 7), VIN off, one dyfa rising edge.
  - Required response: lout=120, rout=0, sample_valid pulse 4 clocks after acceptance.
- Full-scale mix:
  - Setup: all amps=15, all active, both mixers=1111, both VIN on with vin_amp=15, volumes 7.
  - Required response: lout=rout=600.
  - Then nrvolume=111 -> rout=75. nch3_active=1 -> both sums drop by 15 × (vol+1).
- Snapshot isolation: change ch2_amp from 4 to 9 one clock after acceptance -> current frame uses 4; the next frame uses 9.
- Back-to-back and overrun:
  - Continuous 1 MHz dyfa -> sample_valid every 4th clock, overrun stays 0.
  - Inject an extra rising edge 2 clocks after acceptance -> overrun=1, frame output unchanged, next regular edge still accepted.
- Mid-frame reset: assert napu_reset during step 1 -> outputs 0. After release and the next edge, a fresh correct result (e.g. 120 for the single-channel setup).
